// File: rtl/inst_fetch_buffer_pkg.sv
// inst_fetch_buffer_pkg: shared entry layout and sizing for the instruction fetch buffer
package inst_fetch_buffer_pkg;
    localparam int FB_DEPTH = 8;
    typedef struct packed {
        logic [13:0] exception_cause;
        logic [1:0]  is_exception;
        logic [31:0] pre_addr;
        logic        pretaken;
        logic [31:0] inst;
        logic [31:0] pc;
    } fb_entry_t;
endpackage

// File: rtl/inst_fetch_buffer_fb_ram.sv
// fb_ram: flop-array entry store with two write ports and two asynchronous read ports
module fb_ram
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [1:0]            we,
    input  logic [1:0][PTR_W-1:0] waddr,
    input  fb_entry_t [1:0]       wdata,
    input  logic [1:0][PTR_W-1:0] raddr,
    output fb_entry_t [1:0]       rdata
);
    fb_entry_t mem [DEPTH];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (we[i]) mem[waddr[i]] <= wdata[i];
    end
    assign rdata = {mem[raddr[1]], mem[raddr[0]]};
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: dual-lane circular FIFO between fetch and decode
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       if_valid,
    input  logic [1:0][31:0] if_pc,
    input  logic [1:0][31:0] if_inst,
    input  logic [1:0]       if_pretaken,
    input  logic [1:0][31:0] if_pre_addr,
    input  logic [1:0][1:0]  if_is_exception,
    input  logic [1:0][13:0] if_exception_cause,
    output logic             if_ready,
    input  logic             get_data_req,
    output logic [1:0]       valid,
    output logic [1:0][31:0] pc,
    output logic [1:0][31:0] inst,
    output logic [1:0]       pretaken,
    output logic [1:0][31:0] pre_addr,
    output logic [1:0][1:0]  is_exception,
    output logic [1:0][13:0] exception_cause
);
    fb_entry_t [1:0]       lane, wdata, rdata, out_q;
    logic [PTR_W-1:0]      head, tail;
    logic [PTR_W:0]        count, n_enq, n_deq;
    logic [1:0]            we;
    logic [1:0][PTR_W-1:0] waddr, raddr;
    logic                  keep1, enq_ok, deq_ok;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane[i] = '{exception_cause: if_exception_cause[i], is_exception: if_is_exception[i],
                        pre_addr: if_pre_addr[i], pretaken: if_pretaken[i], inst: if_inst[i], pc: if_pc[i]};
            pc[i] = out_q[i].pc;
            inst[i] = out_q[i].inst;
            pretaken[i] = out_q[i].pretaken;
            pre_addr[i] = out_q[i].pre_addr;
            is_exception[i] = out_q[i].is_exception;
            exception_cause[i] = out_q[i].exception_cause;
        end
    end

    // lane1 is on the wrong path when lane0 redirects or faults
    assign keep1 = if_valid[1] && !(if_valid[0] && (if_pretaken[0] || |if_is_exception[0]));
    assign if_ready = count <= (PTR_W+1)'(DEPTH - 2);
    assign enq_ok = if_ready && !flush;
    assign deq_ok = get_data_req && !flush;
    assign we = {enq_ok && if_valid[0] && keep1, enq_ok && (if_valid[0] || keep1)};
    assign wdata = {lane[1], if_valid[0] ? lane[0] : lane[1]};
    assign waddr = {tail + PTR_W'(1), tail};
    assign raddr = {head + PTR_W'(1), head};
    assign n_enq = (PTR_W+1)'(we[0]) + (PTR_W+1)'(we[1]);
    assign n_deq = !deq_ok ? '0 : count >= (PTR_W+1)'(2) ? (PTR_W+1)'(2) : count;

    fb_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
        .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            head <= head + n_deq[PTR_W-1:0];
            tail <= tail + n_enq[PTR_W-1:0];
            count <= count + n_enq - n_deq;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            out_q <= '0;
        end else if (n_deq == '0) begin
            valid <= '0;
        end else begin
            valid <= {n_deq == (PTR_W+1)'(2), 1'b1};
            out_q <= rdata;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) count <= (PTR_W+1)'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst) valid[1] |-> valid[0]);
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed stimulus with a queue scoreboard checked by a decoupled monitor
module tb_inst_fetch_buffer;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pretaken;
        logic [31:0] pre_addr;
        logic [1:0]  exc;
        logic [13:0] cause;
    } item_t;

    logic             clk = 1'b0, rst, flush, get_data_req, if_ready;
    logic [1:0]       if_valid, if_pretaken, valid, pretaken;
    logic [1:0][31:0] if_pc, if_inst, if_pre_addr, pc, inst, pre_addr;
    logic [1:0][1:0]  if_is_exception, is_exception;
    logic [1:0][13:0] if_exception_cause, exception_cause;
    item_t            exp_q[$];
    int               total = 0, bad = 0;

    always #5 clk = ~clk;

    inst_fetch_buffer dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_pretaken(if_pretaken), .if_pre_addr(if_pre_addr), .if_is_exception(if_is_exception),
        .if_exception_cause(if_exception_cause), .if_ready(if_ready), .get_data_req(get_data_req),
        .valid(valid), .pc(pc), .inst(inst), .pretaken(pretaken), .pre_addr(pre_addr),
        .is_exception(is_exception), .exception_cause(exception_cause)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic item_t mk(input logic [31:0] p, input logic pt = 1'b0,
                                 input logic [1:0] e = 2'b00, input logic [13:0] c = 14'h0);
        return '{pc: p, inst: p ^ 32'h0013_0013, pretaken: pt, pre_addr: p + 32'h40, exc: e, cause: c};
    endfunction

    task automatic beat(input logic [1:0] v, input item_t a, input item_t b);
        if_valid = v;
        {if_pc[0], if_inst[0], if_pretaken[0], if_pre_addr[0], if_is_exception[0], if_exception_cause[0]} = a;
        {if_pc[1], if_inst[1], if_pretaken[1], if_pre_addr[1], if_is_exception[1], if_exception_cause[1]} = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        item_t got, want;
        if (rst) begin
            if (valid[1] && !valid[0]) chk("valid_order", 32'(valid), 32'h3);
            for (int i = 0; i < 2; i++) begin
                if (valid[i]) begin
                    got = '{pc: pc[i], inst: inst[i], pretaken: pretaken[i], pre_addr: pre_addr[i],
                            exc: is_exception[i], cause: exception_cause[i]};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected lane%0d: got pc %0h want nothing", i, got.pc);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            bad++;
                            $display("FAIL sb_lane%0d: got %h want %h", i, got, want);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        get_data_req = 1'b0;
        beat(2'b00, '0, '0);
        #1;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ready", 32'(if_ready), 32'h1);
        chk("rst_pc0", pc[0], 32'h0);
        #11 rst = 1'b1;
        tick();
        // stream: pairs in order, one-cycle latency
        get_data_req = 1'b1;
        beat(2'b11, mk(32'h1c000000), mk(32'h1c000004));
        exp_q.push_back(mk(32'h1c000000));
        exp_q.push_back(mk(32'h1c000004));
        tick();
        chk("stream_latency", 32'(valid), 32'h0);
        beat(2'b11, mk(32'h1c000008), mk(32'h1c00000c));
        exp_q.push_back(mk(32'h1c000008));
        exp_q.push_back(mk(32'h1c00000c));
        tick();
        chk("stream_v1", 32'(valid), 32'h3);
        beat(2'b00, '0, '0);
        tick();
        chk("stream_v2", 32'(valid), 32'h3);
        tick();
        chk("stream_idle", 32'(valid), 32'h0);
        // filter: taken lane0 drops lane1; lone lane1 compacts to lane0
        get_data_req = 1'b0;
        beat(2'b11, mk(32'h100, 1'b1), mk(32'h104));
        exp_q.push_back(mk(32'h100, 1'b1));
        tick();
        beat(2'b00, '0, '0);
        get_data_req = 1'b1;
        tick();
        chk("filt_valid", 32'(valid), 32'h1);
        chk("filt_pc0", pc[0], 32'h100);
        beat(2'b10, '0, mk(32'h204));
        exp_q.push_back(mk(32'h204));
        tick();
        chk("filt_no_bypass", 32'(valid), 32'h0);
        beat(2'b00, '0, '0);
        tick();
        chk("compact_valid", 32'(valid), 32'h1);
        chk("compact_pc0", pc[0], 32'h204);
        // back-pressure: fill to 7 across the wrap, then drain 2,2,2,1
        get_data_req = 1'b0;
        beat(2'b01, mk(32'h600), '0);
        exp_q.push_back(mk(32'h600));
        tick();
        chk("bp_ready1", 32'(if_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            beat(2'b11, mk(32'h604 + 32'(8 * k)), mk(32'h608 + 32'(8 * k)));
            exp_q.push_back(mk(32'h604 + 32'(8 * k)));
            exp_q.push_back(mk(32'h608 + 32'(8 * k)));
            tick();
            chk("bp_ready", 32'(if_ready), k == 2 ? 32'h0 : 32'h1);
        end
        beat(2'b11, mk(32'h900), mk(32'h904));
        tick();
        chk("bp_ignored", 32'(if_ready), 32'h0);
        beat(2'b00, '0, '0);
        get_data_req = 1'b1;
        tick();
        chk("drain1", 32'(valid), 32'h3);
        chk("drain_ready", 32'(if_ready), 32'h1);
        tick();
        chk("drain2", 32'(valid), 32'h3);
        tick();
        chk("drain3", 32'(valid), 32'h3);
        tick();
        chk("drain4", 32'(valid), 32'h1);
        tick();
        chk("drain_empty", 32'(valid), 32'h0);
        // flush with concurrent enqueue and dequeue
        get_data_req = 1'b0;
        beat(2'b11, mk(32'h700), mk(32'h704));
        tick();
        beat(2'b11, mk(32'h708), mk(32'h70c));
        tick();
        beat(2'b01, mk(32'h710), '0);
        tick();
        beat(2'b11, mk(32'h7f0), mk(32'h7f4));
        get_data_req = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_valid", 32'(valid), 32'h0);
        chk("flush_ready", 32'(if_ready), 32'h1);
        flush = 1'b0;
        beat(2'b00, '0, '0);
        tick();
        chk("flush_empty", 32'(valid), 32'h0);
        beat(2'b01, mk(32'h300), '0);
        exp_q.push_back(mk(32'h300));
        tick();
        chk("flush_nobypass", 32'(valid), 32'h0);
        beat(2'b00, '0, '0);
        tick();
        chk("flush_next_valid", 32'(valid), 32'h1);
        chk("flush_next_pc", pc[0], 32'h300);
        // exception on lane0 drops lane1 and carries tags through
        get_data_req = 1'b0;
        beat(2'b11, mk(32'h400, 1'b0, 2'b01, 14'h08), mk(32'h404));
        exp_q.push_back(mk(32'h400, 1'b0, 2'b01, 14'h08));
        tick();
        beat(2'b00, '0, '0);
        get_data_req = 1'b1;
        tick();
        chk("exc_valid", 32'(valid), 32'h1);
        chk("exc_flags", 32'(is_exception[0]), 32'h1);
        chk("exc_cause", 32'(exception_cause[0]), 32'h8);
        // asynchronous reset mid-traffic
        get_data_req = 1'b0;
        beat(2'b11, mk(32'h500), mk(32'h504));
        exp_q.push_back(mk(32'h500));
        exp_q.push_back(mk(32'h504));
        tick();
        beat(2'b11, mk(32'h508), mk(32'h50c));
        tick();
        beat(2'b00, '0, '0);
        get_data_req = 1'b1;
        tick();
        chk("pre_rst_valid", 32'(valid), 32'h3);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_ready", 32'(if_ready), 32'h1);
        chk("arst_pc0", pc[0], 32'h0);
        #1 rst = 1'b1;
        tick();
        chk("post_rst_empty1", 32'(valid), 32'h0);
        tick();
        chk("post_rst_empty2", 32'(valid), 32'h0);
        beat(2'b11, mk(32'h800), mk(32'h804));
        exp_q.push_back(mk(32'h800));
        exp_q.push_back(mk(32'h804));
        tick();
        beat(2'b00, '0, '0);
        tick();
        chk("post_rst_valid", 32'(valid), 32'h3);
        tick();
        chk("post_rst_idle", 32'(valid), 32'h0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
